dart_turn_scheduler: RTL
========================

# dart_turn_scheduler

Sequences a two-player dart game. Buffers incoming dart hits, hands each hit to the scoring unit over a valid/ack handshake tagged with the owning player, and counts darts per turn. It alternates turns between the players and latches game-over when the scorer reports a win. It sits between the dart sensor interface (dart_come/position) and the scoring datapath, and produces the turn/win status seen by the pattern side.

## Interface
Parameters:
- DARTS_PER_TURN, 3, darts per turn; legal 1..3
- FIFO_DEPTH, 4, hit buffer entries; power of two, 2..8
- TIMEOUT_CYCLES, 1000, idle cycles before a turn is forfeited (used only with DART_SCHED_TIMEOUT_EN)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- dart_come_i  in  1  one-cycle pulse: a dart landed
- dart_position_x_i  in  8  hit x coordinate, valid with dart_come_i
- dart_position_y_i  in  8  hit y coordinate, valid with dart_come_i
- score_req_o  out  1  request to scorer; head hit is valid
- score_x_o  out  8  head hit x
- score_y_o  out  8  head hit y
- score_player_o  out  1  owner of head hit: 0 = player 1, 1 = player 2
- score_ack_i  in  1  scorer accepts the request this cycle
- score_bust_i  in  1  result of the accepted dart, valid with ack: bust
- score_win_i  in  1  result of the accepted dart, valid with ack: player reached zero
- active_player_o  out  1  current turn owner
- dart_count_o  out  2  darts already scored this turn
- player_1_done_o  out  1  one-cycle pulse: player 1 turn ended
- player_2_done_o  out  1  one-cycle pulse: player 2 turn ended
- player_1_win_o  out  1  level: player 1 won
- player_2_win_o  out  1  level: player 2 won
- game_set_o  out  1  level: game over
- overflow_o  out  1  sticky: a hit was dropped

## Operation
- Reset values: all outputs 0, FIFO empty, state RUN, active player 1.
- FIFO push: when dart_come_i=1 and state is not OVER, the entry is written at that clock edge. If the FIFO is full and no pop occurs in the same cycle, the hit is dropped and overflow_o is set until reset. If full with a simultaneous pop, the hit is accepted. In OVER, dart_come_i is ignored and does not set overflow_o.
- FSM states:
  - RUN: score_req_o = FIFO not empty. score_x/y_o = FIFO head; score_player_o = active_player_o. A transfer occurs when score_req_o and score_ack_i are both 1; the head is popped at that edge.
    - On a transfer with win: go to OVER. Set game_set_o and the winner's win output, both held until reset.
    - Else on bust: go to TURN_END.
    - Else: dart_count increments. If the new count equals DARTS_PER_TURN, go to TURN_END.
    - win has priority over bust.
  - TURN_END (1 cycle): score_req_o=0. Pulse the active player's done output. At exit: dart_count=0, active player toggles, return to RUN. Queued hits remain and belong to the next player.
  - OVER: score_req_o=0; all status frozen; only reset leaves.
- score_ack_i, score_bust_i and score_win_i are ignored when score_req_o=0.
- Request payload is held stable while score_req_o=1 and no ack is seen.

## Timing
- Hit pulse in cycle t with FIFO empty in RUN: score_req_o=1 in cycle t+1.
- Ack in cycle t: next head is presented in t+1 if the FIFO is still non-empty and state stays RUN.
- Turn end: the done pulse falls in the cycle after the ending ack. active_player_o and dart_count_o change one cycle after that.
- Win: game_set_o and the win output rise one cycle after the ack.
- Reset asserted mid-turn or mid-request: outputs go to reset values immediately and the FIFO contents are discarded.

## Configuration
- DART_SCHED_TIMEOUT_EN defined:
  - In RUN with the FIFO empty, an idle counter increments each cycle. It clears on any push or transfer, and on entering RUN.
  - When it reaches TIMEOUT_CYCLES, go to TURN_END; the remaining darts of the turn are forfeited. This applies even when dart_count is 0.
- Not defined: no counter is built; RUN waits indefinitely; TIMEOUT_CYCLES is unused.

## Test plan
- 3 hits, ack each the cycle after req, no bust/win -> score_player_o=0 for all; player_1_done_o pulses once; active_player_o=1; dart_count_o=0.
- 5 hits in 5 consecutive cycles with score_ack_i held 0 (depth 4) -> 4 hits buffered, overflow_o=1; after acks, exactly 4 requests with the first 4 coordinates in order.
- Bust on first dart of player 1 with 2 hits queued -> player_1_done_o pulses; both queued hits are issued with score_player_o=1.
- Win on second dart of player 2 -> player_2_win_o=1, game_set_o=1, player_1_win_o=0; further dart_come_i gives no score_req_o and no overflow.
- Reset asserted while score_req_o=1 with 3 hits queued -> all outputs 0 asynchronously; no request after reset release until a new hit.
- With DART_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, one scored dart then idle -> player_1_done_o pulses after 16 idle cycles; without the macro, no pulse after 1000 cycles.

Source files
------------

// File: rtl/dart_turn_scheduler_if.sv
// rtl/dart_turn_scheduler_if.sv - sensor, scorer and status signals of the dart turn scheduler
interface dart_turn_scheduler_if;
  logic       dart_come_i;
  logic [7:0] dart_position_x_i;
  logic [7:0] dart_position_y_i;
  logic       score_req_o;
  logic [7:0] score_x_o;
  logic [7:0] score_y_o;
  logic       score_player_o;
  logic       score_ack_i;
  logic       score_bust_i;
  logic       score_win_i;
  logic       active_player_o;
  logic [1:0] dart_count_o;
  logic       player_1_done_o;
  logic       player_2_done_o;
  logic       player_1_win_o;
  logic       player_2_win_o;
  logic       game_set_o;
  logic       overflow_o;

  // scheduler side
  modport slave (
    input  dart_come_i, dart_position_x_i, dart_position_y_i,
    input  score_ack_i, score_bust_i, score_win_i,
    output score_req_o, score_x_o, score_y_o, score_player_o,
    output active_player_o, dart_count_o, player_1_done_o, player_2_done_o,
    output player_1_win_o, player_2_win_o, game_set_o, overflow_o
  );

  // sensor / scorer / status side
  modport master (
    output dart_come_i, dart_position_x_i, dart_position_y_i,
    output score_ack_i, score_bust_i, score_win_i,
    input  score_req_o, score_x_o, score_y_o, score_player_o,
    input  active_player_o, dart_count_o, player_1_done_o, player_2_done_o,
    input  player_1_win_o, player_2_win_o, game_set_o, overflow_o
  );
endinterface

// File: rtl/dart_turn_scheduler.sv
// rtl/dart_turn_scheduler.sv - two-player dart hit buffer and turn sequencer; optional idle forfeit via DART_SCHED_TIMEOUT_EN
module dart_turn_scheduler #(
  parameter int DARTS_PER_TURN = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic clk,
  input logic reset,
  dart_turn_scheduler_if.slave bus
);
  localparam int           AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  LP_DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [1:0]   LP_DPT   = 2'(DARTS_PER_TURN);

  typedef enum logic [1:0] {S_RUN, S_TURN_END, S_OVER} state_t;

  state_t          r_state, w_state_nxt;
  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_active, r_overflow, r_p1_win, r_p2_win;
  logic [1:0]      r_dart_count;

  logic            w_empty, w_full, w_req, w_xfer, w_come, w_push, w_drop, w_timeout;
  logic [1:0]      w_cnt_inc;
  logic [15:0]     w_head;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == LP_DEPTH);
  assign w_req     = (r_state == S_RUN) && !w_empty;
  assign w_xfer    = w_req && bus.score_ack_i;
  assign w_come    = bus.dart_come_i && (r_state != S_OVER);
  // a full buffer still takes the hit when the head leaves in the same cycle
  assign w_push    = w_come && (!w_full || w_xfer);
  assign w_drop    = w_come && w_full && !w_xfer;
  assign w_cnt_inc = r_dart_count + 2'd1;
  assign w_head    = r_mem[r_rd_ptr];

`ifdef DART_SCHED_TIMEOUT_EN
  localparam int          TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LP_TO = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] r_idle;

  // idle counter: runs only in RUN with nothing queued, restarts on any activity
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle <= '0;
    end else if (r_state != S_RUN || w_push || w_xfer) begin
      r_idle <= '0;
    end else if (w_empty && r_idle != LP_TO) begin
      r_idle <= r_idle + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_RUN) && (r_idle == LP_TO);
`else
  // without the forfeit feature RUN waits forever; the term below is constant 0
  assign w_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // hit storage; contents need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.dart_position_x_i, bus.dart_position_y_i};
  end

  // buffer pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_xfer) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_xfer})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  // next-state: win beats bust, bust beats the dart count
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (w_xfer) begin
          if (bus.score_win_i)        w_state_nxt = S_OVER;
          else if (bus.score_bust_i)  w_state_nxt = S_TURN_END;
          else if (w_cnt_inc == LP_DPT) w_state_nxt = S_TURN_END;
        end else if (w_timeout) begin
          w_state_nxt = S_TURN_END;
        end
      end
      S_TURN_END: w_state_nxt = S_RUN;
      S_OVER:     w_state_nxt = S_OVER;
      default:    w_state_nxt = S_RUN;
    endcase
  end

  // turn bookkeeping, winner latch and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dart_count <= 2'd0;
      r_active     <= 1'b0;
      r_p1_win     <= 1'b0;
      r_p2_win     <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_xfer && !bus.score_win_i && !bus.score_bust_i) r_dart_count <= w_cnt_inc;
      if (r_state == S_TURN_END) begin
        r_dart_count <= 2'd0;
        r_active     <= ~r_active;
      end
      if (w_xfer && bus.score_win_i) begin
        if (r_active) r_p2_win <= 1'b1;
        else          r_p1_win <= 1'b1;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign bus.score_req_o     = w_req;
  assign bus.score_x_o       = w_req ? w_head[15:8] : 8'd0;
  assign bus.score_y_o       = w_req ? w_head[7:0]  : 8'd0;
  assign bus.score_player_o  = r_active;
  assign bus.active_player_o = r_active;
  assign bus.dart_count_o    = r_dart_count;
  assign bus.player_1_done_o = (r_state == S_TURN_END) && !r_active;
  assign bus.player_2_done_o = (r_state == S_TURN_END) &&  r_active;
  assign bus.player_1_win_o  = r_p1_win;
  assign bus.player_2_win_o  = r_p2_win;
  assign bus.game_set_o      = (r_state == S_OVER);
  assign bus.overflow_o      = r_overflow;
endmodule
